// File: rtl/rsa_arbiter_if.sv
// rtl/rsa_arbiter_if.sv - requester-side handshake bundle for the two-port RSA arbiter
interface rsa_arbiter_if #(
  parameter int WIDTH = 8
);
  logic               req0_valid;
  logic               req1_valid;
  logic [4*WIDTH-1:0] req0_ops;
  logic [4*WIDTH-1:0] req1_ops;
  logic               req0_ready;
  logic               req1_ready;
  logic               req0_done;
  logic               req1_done;
  logic               req0_err;
  logic               req1_err;
  logic [WIDTH-1:0]   req0_c;
  logic [WIDTH-1:0]   req1_c;

  modport slave (
    input  req0_valid, req1_valid, req0_ops, req1_ops,
    output req0_ready, req1_ready, req0_done, req1_done,
    output req0_err, req1_err, req0_c, req1_c
  );

  modport master (
    output req0_valid, req1_valid, req0_ops, req1_ops,
    input  req0_ready, req1_ready, req0_done, req1_done,
    input  req0_err, req1_err, req0_c, req1_c
  );
endinterface

// File: rtl/rsa_arbiter.sv
// rtl/rsa_arbiter.sv - round-robin arbiter sharing one RSA unit between two requesters
module rsa_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  rsa_arbiter_if.slave       req,
  input  logic               abort,
  input  logic               irq_clr,
  output logic               irq,
  output logic               busy,
  output logic               owner,
  output logic               rsa_en,
  output logic               rsa_rstb,
  output logic [4*WIDTH-1:0] rsa_ops,
  input  logic               rsa_eoc,
  input  logic [WIDTH-1:0]   rsa_c
);
  localparam logic [9:0] TMO = 10'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic [4*WIDTH-1:0] ops_q, ops_d;
  logic [WIDTH-1:0]   c0_q, c0_d, c1_q, c1_d;
  logic               err0_q, err0_d, err1_q, err1_d;
  logic               irq_q, irq_d;

  logic any_valid;
  logic grant;
  logic accept;

  // Ties go to whichever requester did not win last time.
  assign any_valid = req.req0_valid | req.req1_valid;
  assign grant     = (req.req0_valid && req.req1_valid) ? ~last_grant_q : req.req1_valid;
  assign accept    = (state_q == S_IDLE) && any_valid && ena && rst_n;

  assign req.req0_ready = accept && !grant;
  assign req.req1_ready = accept && grant;
  assign req.req0_done  = (state_q == S_DONE) && !owner_q;
  assign req.req1_done  = (state_q == S_DONE) && owner_q;
  assign req.req0_err   = err0_q;
  assign req.req1_err   = err1_q;
  assign req.req0_c     = c0_q;
  assign req.req1_c     = c1_q;

  assign irq      = irq_q;
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;
  assign rsa_en   = (state_q == S_RUN);
  assign rsa_rstb = (state_q == S_RUN) || (state_q == S_DONE);
  assign rsa_ops  = ops_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ops_d        = ops_q;
    c0_d         = c0_q;
    c1_d         = c1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    irq_d        = irq_clr ? 1'b0 : irq_q;

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          owner_d      = grant;
          last_grant_d = grant;
          ops_d        = grant ? req.req1_ops : req.req0_ops;
          if (grant) err1_d = 1'b0;
          else       err0_d = 1'b0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 10'd1;
        // Abort beats eoc, and eoc beats a coincident timeout.
        if (abort) begin
          state_d = S_IDLE;
        end else if (rsa_eoc) begin
          if (owner_q) c1_d = rsa_c;
          else         c0_d = rsa_c;
          state_d = S_DONE;
        end else if (cnt_q == TMO) begin
          if (owner_q) err1_d = 1'b1;
          else         err0_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ops_q        <= '0;
      c0_q         <= '0;
      c1_q         <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ops_q        <= ops_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      irq_q        <= irq_d;
    end
  end
endmodule

// File: doc/rsa_arbiter.md
RSA_ARBITER -- requirements
Module: rsa_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 1023, maximum RUN cycles before abort-with-error; counter width 10.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ena  in  1  design enable; low freezes all state (reset still applies).
REQ-006 reqN_valid  in  1  (N=0,1) requester N has a job pending.
REQ-007 reqN_ops  in  4*WIDTH  job operands packed {const,m,e,p}, p in LSBs.
REQ-008 reqN_ready  out  1  combinational accept; transfer when valid&&ready.
REQ-009 reqN_done  out  1  one-cycle completion pulse for requester N.
REQ-010 reqN_err  out  1  level; set on timeout of N's job, cleared when N's next job is accepted.
REQ-011 reqN_c  out  WIDTH  last result for requester N, held until N's next completion.
REQ-012 abort  in  1  cancel current job.
REQ-013 irq_clr  in  1  clear irq.
REQ-014 irq  out  1  level, any job finished (ok or err).
REQ-015 busy  out  1  high in LOAD, RUN, DONE.
REQ-016 owner  out  1  index of requester holding the RSA unit (valid while busy).
REQ-017 rsa_en  out  1  RSA unit enable.
REQ-018 rsa_rstb  out  1  RSA unit reset, active-low.
REQ-019 rsa_ops  out  4*WIDTH  registered operands to RSA unit, same packing as reqN_ops.
REQ-020 rsa_eoc  in  1  RSA unit end of computation.
REQ-021 rsa_c  in  WIDTH  RSA unit result.

Function
REQ-022 FSM states IDLE, LOAD, RUN, DONE; no state changes while ena=0.
REQ-023 IDLE: rsa_en=0, rsa_rstb=0; if any valid, grant one requester, reqN_ready=1 for granted N only, capture reqN_ops into rsa_ops, set owner, clear reqN_err, -> LOAD.
REQ-024 Arbitration round-robin: both valid -> grant the requester not granted last; one valid -> grant it; last_grant updates on each grant.
REQ-025 LOAD (1 cycle): rsa_rstb=0, rsa_en=0, timeout counter cleared -> RUN.
REQ-026 RUN: rsa_rstb=1, rsa_en=1, counter increments each cycle.
REQ-027 RUN and rsa_eoc=1: capture rsa_c into reqN_c of owner -> DONE.
REQ-028 RUN and counter==TIMEOUT with rsa_eoc=0: set reqN_err of owner, reqN_c unchanged -> DONE.
REQ-029 rsa_eoc and timeout in same cycle: eoc wins, no error.
REQ-030 abort in LOAD or RUN: -> IDLE next cycle, no done, no irq, no err, reqN_c unchanged; abort wins over simultaneous eoc; abort ignored in IDLE and DONE.
REQ-031 DONE (1 cycle): rsa_en=0, rsa_rstb=1, reqN_done=1 for owner, irq set -> IDLE.
REQ-032 irq: set in DONE, cleared by irq_clr; set wins over simultaneous clear.
REQ-033 Latency: accept at cycle T, LOAD T+1, RUN from T+2; eoc at cycle E gives done pulse and valid reqN_c at E+1; next grant no earlier than E+2.
REQ-034 Requests arriving while busy wait; no queueing beyond the valid level.

Reset
REQ-035 rst_n=0 at clock edge: state IDLE, rsa_en=0, rsa_rstb=0, rsa_ops=0, reqN_c=0, reqN_err=0, reqN_done=0, irq=0, owner=0, counter=0, last_grant=1 (req0 wins first tie).
REQ-036 Reset mid-RUN aborts the job with no done pulse; reset overrides ena=0.

Verification
REQ-037 req0 ops p=0x0D e=0x05 m=0x07 const=0x04, stub eoc after 20 RUN cycles with rsa_c=0x5A -> req0_ready at T, req0_done at E+1, req0_c=0x5A, irq=1, req1 untouched.
REQ-038 req0 and req1 valid from reset, held -> grant order 0,1,0,1; owner matches; each done pulses once per job.
REQ-039 Stub never asserts eoc -> RUN lasts TIMEOUT+1 cycles, req0_err=1, req0_done pulse, req0_c unchanged, irq=1.
REQ-040 abort asserted on same cycle as rsa_eoc -> IDLE, no done, irq stays 0, reqN_c unchanged.
REQ-041 ena=0 for 5 cycles during RUN -> counter, state and outputs frozen, job completes normally after ena=1.
REQ-042 irq_clr and DONE in same cycle -> irq=1; irq_clr alone next cycle -> irq=0.
